// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_ctrl_pkg
// Brief   : Opcodes, sequencer state encoding and instruction classes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

   localparam logic [4:0] c_op_ld   = 5'd0;
   localparam logic [4:0] c_op_ldi  = 5'd1;
   localparam logic [4:0] c_op_st   = 5'd2;
   localparam logic [4:0] c_op_add  = 5'd3;
   localparam logic [4:0] c_op_sub  = 5'd4;
   localparam logic [4:0] c_op_and  = 5'd5;
   localparam logic [4:0] c_op_or   = 5'd6;
   localparam logic [4:0] c_op_shr  = 5'd7;
   localparam logic [4:0] c_op_shl  = 5'd8;
   localparam logic [4:0] c_op_ror  = 5'd9;
   localparam logic [4:0] c_op_rol  = 5'd10;
   localparam logic [4:0] c_op_addi = 5'd11;
   localparam logic [4:0] c_op_andi = 5'd12;
   localparam logic [4:0] c_op_ori  = 5'd13;
   localparam logic [4:0] c_op_mul  = 5'd14;
   localparam logic [4:0] c_op_div  = 5'd15;
   localparam logic [4:0] c_op_neg  = 5'd16;
   localparam logic [4:0] c_op_not  = 5'd17;
   localparam logic [4:0] c_op_br   = 5'd18;
   localparam logic [4:0] c_op_jr   = 5'd19;
   localparam logic [4:0] c_op_in   = 5'd20;
   localparam logic [4:0] c_op_out  = 5'd21;
   localparam logic [4:0] c_op_mfhi = 5'd22;
   localparam logic [4:0] c_op_mflo = 5'd23;
   localparam logic [4:0] c_op_nop  = 5'd24;
   localparam logic [4:0] c_op_halt = 5'd25;

   // EX states are consecutive so the sequencer can step through them by +1.
   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH0 = 4'd1,
      S_FETCH1 = 4'd2,
      S_FETCH2 = 4'd3,
      S_FETCH3 = 4'd4,
      S_EX0    = 4'd5,
      S_EX1    = 4'd6,
      S_EX2    = 4'd7,
      S_EX3    = 4'd8,
      S_EX4    = 4'd9,
      S_EX5    = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP    = 4'd0,
      CLS_ALU3   = 4'd1,
      CLS_ALUI   = 4'd2,
      CLS_MULDIV = 4'd3,
      CLS_UNARY  = 4'd4,
      CLS_LD     = 4'd5,
      CLS_LDI    = 4'd6,
      CLS_ST     = 4'd7,
      CLS_BR     = 4'd8,
      CLS_JR     = 4'd9,
      CLS_IN     = 4'd10,
      CLS_OUT    = 4'd11,
      CLS_MFHI   = 4'd12,
      CLS_MFLO   = 4'd13,
      CLS_HALT   = 4'd14
   } op_class_t;

   function automatic state_t last_state(input op_class_t cls);
      case (cls)
         CLS_ALU3, CLS_ALUI, CLS_LDI: return S_EX2;
         CLS_MULDIV, CLS_BR:          return S_EX3;
         CLS_UNARY:                   return S_EX1;
         CLS_LD:                      return S_EX5;
         CLS_ST:                      return S_EX4;
         default:                     return S_EX0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : control_sequencer_if
// Brief   : Control bundle between the sequencer (master) and datapath (slave).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface control_sequencer_if;
   logic [31:0] ir;
   logic        con_ff;
   logic        stop;

   logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout;
   logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHIin, ZLOin;
   logic IncPC, Read, RAM_wr_enable, CONin, enable_outPort;
   logic GRA, GRB, GRC, R_in, R_out, Baout;
   logic [4:0] operation;
   logic       run;

   modport master (
      input  ir, con_ff, stop,
      output PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout,
      output PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHIin, ZLOin,
      output IncPC, Read, RAM_wr_enable, CONin, enable_outPort,
      output GRA, GRB, GRC, R_in, R_out, Baout, operation, run
   );

   modport slave (
      output ir, con_ff, stop,
      input  PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout,
      input  PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHIin, ZLOin,
      input  IncPC, Read, RAM_wr_enable, CONin, enable_outPort,
      input  GRA, GRB, GRC, R_in, R_out, Baout, operation, run
   );
endinterface

`default_nettype wire

// File: rtl/op_class_decode.sv
//------------------------------------------------------------------------------
// Module  : op_class_decode
// Brief   : Maps a 5-bit opcode to its execute-sequence class.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module op_class_decode
   import cpu_ctrl_pkg::*;
(
   input  wire logic [4:0] i_opcode,
   output op_class_t       o_class
);

   always_comb begin
      o_class = CLS_NOP;
      case (i_opcode)
         c_op_add, c_op_sub, c_op_and, c_op_or,
         c_op_shr, c_op_shl, c_op_ror, c_op_rol: o_class = CLS_ALU3;
         c_op_addi, c_op_andi, c_op_ori:         o_class = CLS_ALUI;
         c_op_mul, c_op_div:                     o_class = CLS_MULDIV;
         c_op_neg, c_op_not:                     o_class = CLS_UNARY;
         c_op_ld:                                o_class = CLS_LD;
         c_op_ldi:                               o_class = CLS_LDI;
         c_op_st:                                o_class = CLS_ST;
         c_op_br:                                o_class = CLS_BR;
         c_op_jr:                                o_class = CLS_JR;
         c_op_in:                                o_class = CLS_IN;
         c_op_out:                               o_class = CLS_OUT;
         c_op_mfhi:                              o_class = CLS_MFHI;
         c_op_mflo:                              o_class = CLS_MFLO;
         c_op_halt:                              o_class = CLS_HALT;
         default:                                o_class = CLS_NOP;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// Module  : control_sequencer
// Brief   : Hardwired Moore control unit for the single-bus CPU datapath.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  wire logic           clk,
   input  wire logic           clr,
   control_sequencer_if.master bus
);

   state_t     r_state;
   op_class_t  w_class;
   logic [4:0] w_opcode;

   assign w_opcode = bus.ir[31:27];

   op_class_decode u_decode (
      .i_opcode (w_opcode),
      .o_class  (w_class)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_RESET;
      end else begin
         case (r_state)
            S_RESET:  r_state <= S_FETCH0;
            S_FETCH0: r_state <= bus.stop ? S_HALT : S_FETCH1;
            S_FETCH1: r_state <= S_FETCH2;
            S_FETCH2: r_state <= S_FETCH3;
            S_FETCH3: begin
               case (w_class)
                  CLS_NOP:  r_state <= S_FETCH0;
                  CLS_HALT: r_state <= S_HALT;
                  default:  r_state <= S_EX0;
               endcase
            end
            S_EX0, S_EX1, S_EX2, S_EX3, S_EX4, S_EX5: begin
               if (r_state == last_state(w_class))
                  r_state <= S_FETCH0;
               else
                  r_state <= state_t'(r_state + 4'd1);
            end
            S_HALT:   r_state <= S_HALT;
            default:  r_state <= S_RESET;
         endcase
      end
   end

   always_comb begin
      {bus.PCout, bus.ZHighout, bus.ZLowout, bus.MDRout,
       bus.HIout, bus.LOout, bus.InPortout, bus.Cout}                     = '0;
      {bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin,
       bus.HIin, bus.LOin, bus.ZHIin, bus.ZLOin}                          = '0;
      {bus.IncPC, bus.Read, bus.RAM_wr_enable, bus.CONin, bus.enable_outPort} = '0;
      {bus.GRA, bus.GRB, bus.GRC, bus.R_in, bus.R_out, bus.Baout}         = '0;
      bus.operation = 5'd0;
      bus.run       = (r_state != S_RESET) && (r_state != S_HALT);

      case (r_state)
         S_FETCH0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.ZLOin = 1'b1; end
         S_FETCH1: begin bus.ZLowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; end
         S_FETCH2: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
         S_FETCH3: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         S_EX0, S_EX1, S_EX2, S_EX3, S_EX4, S_EX5: begin
            case (w_class)
               CLS_ALU3, CLS_ALUI: begin
                  case (r_state)
                     S_EX0: begin bus.GRB = 1'b1; bus.R_out = 1'b1; bus.Yin = 1'b1; end
                     S_EX1: begin
                        // Immediate forms take operand B from the C-sign-extend path.
                        if (w_class == CLS_ALUI) bus.Cout = 1'b1;
                        else begin bus.GRC = 1'b1; bus.R_out = 1'b1; end
                        bus.operation = w_opcode;
                        bus.ZLOin     = 1'b1;
                     end
                     S_EX2: begin bus.ZLowout = 1'b1; bus.GRA = 1'b1; bus.R_in = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_MULDIV: begin
                  case (r_state)
                     S_EX0: begin bus.GRA = 1'b1; bus.R_out = 1'b1; bus.Yin = 1'b1; end
                     S_EX1: begin
                        bus.GRB = 1'b1; bus.R_out = 1'b1; bus.operation = w_opcode;
                        bus.ZLOin = 1'b1; bus.ZHIin = 1'b1;
                     end
                     S_EX2: begin bus.ZLowout = 1'b1; bus.LOin = 1'b1; end
                     S_EX3: begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_UNARY: begin
                  case (r_state)
                     S_EX0: begin
                        bus.GRB = 1'b1; bus.R_out = 1'b1; bus.operation = w_opcode; bus.ZLOin = 1'b1;
                     end
                     S_EX1: begin bus.ZLowout = 1'b1; bus.GRA = 1'b1; bus.R_in = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_LD, CLS_LDI, CLS_ST: begin
                  case (r_state)
                     S_EX0: begin bus.GRB = 1'b1; bus.R_out = 1'b1; bus.Baout = 1'b1; bus.Yin = 1'b1; end
                     S_EX1: begin bus.Cout = 1'b1; bus.operation = c_op_add; bus.ZLOin = 1'b1; end
                     S_EX2: begin
                        bus.ZLowout = 1'b1;
                        if (w_class == CLS_LDI) begin bus.GRA = 1'b1; bus.R_in = 1'b1; end
                        else bus.MARin = 1'b1;
                     end
                     S_EX3: begin
                        if (w_class == CLS_ST) begin bus.GRA = 1'b1; bus.R_out = 1'b1; bus.MDRin = 1'b1; end
                        else bus.Read = 1'b1;
                     end
                     S_EX4: begin
                        if (w_class == CLS_ST) bus.RAM_wr_enable = 1'b1;
                        else begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                     end
                     S_EX5: begin bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.R_in = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_BR: begin
                  case (r_state)
                     S_EX0: begin bus.GRA = 1'b1; bus.R_out = 1'b1; bus.CONin = 1'b1; end
                     S_EX1: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                     S_EX2: begin bus.Cout = 1'b1; bus.operation = c_op_add; bus.ZLOin = 1'b1; end
                     S_EX3: begin bus.ZLowout = 1'b1; bus.PCin = bus.con_ff; end
                     default: ;
                  endcase
               end
               CLS_JR:   begin bus.GRA = 1'b1; bus.R_out = 1'b1; bus.PCin = 1'b1; end
               CLS_IN:   begin bus.InPortout = 1'b1; bus.GRA = 1'b1; bus.R_in = 1'b1; end
               CLS_OUT:  begin bus.GRA = 1'b1; bus.R_out = 1'b1; bus.enable_outPort = 1'b1; end
               CLS_MFHI: begin bus.HIout = 1'b1; bus.GRA = 1'b1; bus.R_in = 1'b1; end
               CLS_MFLO: begin bus.LOout = 1'b1; bus.GRA = 1'b1; bus.R_in = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire
